ibex_register_file_remap: RTL
=============================

IBEX_REGISTER_FILE_REMAP -- requirements
Module: ibex_register_file_remap

Interface
REQ-001 The module SHALL have parameter RV32E, default 0, meaning 16 architectural registers when 1 and 32 when 0; NUM_WORDS = 16 or 32.
REQ-002 The module SHALL have parameter DataWidth, default 32, meaning the register data width.
REQ-003 The module SHALL have parameter NumSpare, default 2 (legal 1..8), meaning the number of spare physical registers in the free pool.
REQ-004 The module SHALL have parameter NumRead, default 2 (legal 1..4), meaning the number of read ports.
REQ-005 The module SHALL have port clk_i, input, 1 bit: clock.
REQ-006 The module SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-007 The module SHALL have port raddr_i, input, NumRead x 5 bits: architectural read addresses.
REQ-008 The module SHALL have port rdata_o, output, NumRead x DataWidth bits: read data.
REQ-009 The module SHALL have port waddr_i, input, 5 bits: architectural write address.
REQ-010 The module SHALL have port wdata_i, input, DataWidth bits: write data.
REQ-011 The module SHALL have port we_i, input, 1 bit: write request.
REQ-012 The module SHALL have port ready_o, output, 1 bit: the free pool is non-empty and a write can be accepted.
REQ-013 The module SHALL have port free_cnt_o, output, 4 bits: number of free physical registers.
REQ-014 The module SHALL have port scrub_busy_o, output, 1 bit: the scrub state machine is not in IDLE.

Function
REQ-015 Physical registers SHALL be P1..P(NUM_WORDS-1+NumSpare); physical index 0 is a constant zero; physical indices are 6 bits wide.
REQ-016 A map table SHALL hold one physical index per architectural register 1..NUM_WORDS-1; architectural register 0 always maps to physical index 0.
REQ-017 The free pool SHALL be a circular FIFO of depth NumSpare holding idle physical indices.
REQ-018 Reads SHALL be combinational: rdata_o[k] = phys[map[raddr_i[k]]].
  - A read in the same cycle as a write returns the pre-write value.
  - raddr 0 returns 0.
  - With RV32E=1, raddr >= 16 returns 0.
REQ-019 A write SHALL be accepted when we_i & ready_o & waddr_i != 0, and with RV32E=1 also waddr_i < 16. On acceptance, in the same clock edge:
  - the free-pool head H is popped;
  - phys[H] <= wdata_i;
  - map[waddr_i] <= H;
  - the old index O = map[waddr_i] is retired per REQ-031/REQ-032.
REQ-020 A write with we_i low, a write to R0, a write to an illegal RV32E address, or a write while ready_o is low SHALL change no state; the upstream stage holds the write until ready_o is high.
REQ-021 ready_o SHALL equal (free_cnt_o != 0) and SHALL be combinational from state only.
REQ-022 A push to and a pop from the free pool in the same cycle SHALL both take effect, with free_cnt_o unchanged; a push to a full pool is impossible by construction.
REQ-023 The invariant free_cnt + dirty_cnt + (scrub FSM holding an index) = NumSpare SHALL hold every cycle.

Reset
REQ-024 On rst_ni low, asynchronously, every physical register SHALL reset to 0.
REQ-025 On rst_ni low, map[i] SHALL reset to i.
REQ-026 On rst_ni low, the free pool SHALL reset to hold NUM_WORDS..NUM_WORDS+NumSpare-1, head = NUM_WORDS.
REQ-027 On rst_ni low, the dirty FIFO SHALL be empty, the FSM SHALL be in IDLE, free_cnt_o SHALL be NumSpare, ready_o SHALL be 1 and scrub_busy_o SHALL be 0.
REQ-028 Reset asserted mid-scrub SHALL abandon the scrub; after reset, state equals the power-on state.

Configuration
REQ-029 Macro RF_SCRUB_EN SHALL select the retirement mode.
REQ-030 Both modes SHALL expose identical ports.
REQ-031 Without RF_SCRUB_EN, O SHALL be zeroed on the write edge and pushed to the free-pool tail on the same edge; free_cnt_o stays constant and ready_o stays 1, so scrub_busy_o is tied to 0.
REQ-032 With RF_SCRUB_EN, O SHALL be pushed to a dirty FIFO (depth NumSpare).
  - The FSM runs IDLE -> ZERO -> RELEASE -> IDLE.
  - IDLE: if the dirty FIFO is non-empty, pop into idx_q and go to ZERO.
  - ZERO: phys[idx_q] <= 0, then go to RELEASE.
  - RELEASE: push idx_q to the free pool, then go to IDLE.
  - A retired index is therefore free again 3 cycles after the write edge.
  - A dirty push and a dirty pop in the same cycle are both honoured.
  - ZERO never targets a mapped register, so it never collides with a write.

Verification
REQ-033 The bench SHALL apply reset, then write x5=0xDEADBEEF, and SHALL observe: rdata x5 = 0xDEADBEEF next cycle, map[5] = 32, old P5 = 0, free_cnt_o = 2.
REQ-034 The bench SHALL write x0=0x1234 with we_i high, and SHALL observe: rdata x0 = 0, free_cnt_o unchanged, no map change.
REQ-035 The bench SHALL issue a read of x7 in the same cycle as a write of x7=0xA5A5A5A5 over old value 0x11, and SHALL observe: rdata = 0x11 that cycle and 0xA5A5A5A5 the next.
REQ-036 With RF_SCRUB_EN and NumSpare=2, the bench SHALL issue back-to-back writes to x1, x2, x3 and SHALL observe:
  - ready_o drops to 0 after the second write;
  - the third write is held;
  - ready_o returns to 1 three cycles after the first write;
  - the third write is accepted into the recycled old P1;
  - the scrubbed register reads 0 before reuse.
REQ-037 The bench SHALL assert reset during an active scrub (ZERO state), and SHALL observe: scrub_busy_o = 0, free_cnt_o = 2 and all reads = 0 immediately.
REQ-038 With RV32E=1, the bench SHALL write x20=0xFF, and SHALL observe no state change and a read of x20 returning 0.

Source files
------------

// File: rtl/ibex_register_file_remap.sv
// ibex_register_file_remap
//
// Register file with renaming. Each architectural register x1..x(NUM_WORDS-1)
// maps to a physical register through a map table. Every accepted write goes
// to a fresh physical register taken from the free pool. The physical register
// it replaces (the "old" index) is retired: it is cleared to zero and then
// returned to the free pool. Physical index 0 is the constant-zero register,
// and x0 always maps to it.
//
// Retirement mode (macro RF_SCRUB_EN):
//   undefined : the old index is zeroed and pushed back to the free pool on
//               the write edge itself. The pool never drains, so ready stays
//               high and scrub_busy is 0.
//   defined   : the old index is queued in a dirty FIFO. A small state machine
//               (IDLE -> ZERO -> RELEASE) clears it and then returns it to the
//               pool. While this runs the pool can run dry, and ready drops.
//
// Handshake: a write is accepted on a clock edge where we & ready & the address
// is a writable register (non-zero, and below 16 when RV32E). If we is high
// while ready is low, no state changes and upstream must hold the write.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   raddr_i      NumRead architectural read addresses (5 bits each)
//   rdata_o      NumRead combinational read data values (pre-write values)
//   waddr_i      architectural write address
//   wdata_i      write data
//   we_i         write request
//   ready_o      the free pool is non-empty, so a write can be accepted
//   free_cnt_o   number of physical registers in the free pool
//   scrub_busy_o the scrub state machine is not in IDLE

module ibex_register_file_remap #(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumSpare  = 2,
    parameter int unsigned NumRead   = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumRead-1:0][4:0]             raddr_i,
    output logic [NumRead-1:0][DataWidth-1:0]   rdata_o,
    input  logic [4:0]                          waddr_i,
    input  logic [DataWidth-1:0]                wdata_i,
    input  logic                                we_i,
    output logic                                ready_o,
    output logic [3:0]                          free_cnt_o,
    output logic                                scrub_busy_o
);

    localparam int NumWords = RV32E ? 16 : 32;
    localparam int NumPhys  = NumWords + int'(NumSpare);
    localparam int IdxW     = 6;
    localparam int PtrW     = (NumSpare > 1) ? $clog2(NumSpare) : 1;

    typedef logic [IdxW-1:0] idx_t;
    typedef logic [PtrW-1:0] ptr_t;

    // Physical register 0 and map entry 0 are constants and not stored.
    logic [DataWidth-1:0] phys_q [1:NumPhys-1];
    idx_t                 map_q  [1:NumWords-1];

    // Free pool: circular FIFO. Full at reset, so head == tail.
    idx_t       free_mem_q [NumSpare];
    ptr_t       free_head_q;
    ptr_t       free_tail_q;
    logic [3:0] free_cnt_q;

    logic [NumRead-1:0][IdxW-1:0] rd_idx;
    logic wr_legal;
    logic accept;
    idx_t old_idx;
    idx_t head_idx;

    // Retirement interface shared by both modes.
    logic free_push;
    idx_t push_idx;
    logic zero_en;
    idx_t zero_idx;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(NumSpare - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ready_o    = (free_cnt_q != 4'd0);
    assign free_cnt_o = free_cnt_q;
    assign head_idx   = free_mem_q[free_head_q];

    // Combinational reads. Addresses not matched by the map loop (x0, and
    // addresses >= 16 under RV32E) keep index 0 and read as zero.
    always_comb begin
        for (int k = 0; k < int'(NumRead); k++) begin
            rd_idx[k] = '0;
            for (int a = 1; a < NumWords; a++) begin
                if (raddr_i[k] == 5'(a)) rd_idx[k] = map_q[a];
            end
            rdata_o[k] = '0;
            for (int p = 1; p < NumPhys; p++) begin
                if (rd_idx[k] == idx_t'(p)) rdata_o[k] = phys_q[p];
            end
        end
    end

    // Write decode.
    always_comb begin
        wr_legal = we_i && (waddr_i != 5'd0) && ({1'b0, waddr_i} < 6'(NumWords));
        accept   = wr_legal && ready_o;
        old_idx  = '0;
        for (int a = 1; a < NumWords; a++) begin
            if (waddr_i == 5'(a)) old_idx = map_q[a];
        end
    end

`ifdef RF_SCRUB_EN
    typedef enum logic [1:0] {
        SCRUB_IDLE    = 2'd0,
        SCRUB_ZERO    = 2'd1,
        SCRUB_RELEASE = 2'd2
    } scrub_state_e;

    scrub_state_e state_q;
    idx_t         idx_q;

    idx_t       dirty_mem_q [NumSpare];
    ptr_t       dirty_head_q;
    ptr_t       dirty_tail_q;
    logic [3:0] dirty_cnt_q;
    logic       dirty_pop;

    assign dirty_pop    = (state_q == SCRUB_IDLE) && (dirty_cnt_q != 4'd0);
    assign free_push    = (state_q == SCRUB_RELEASE);
    assign push_idx     = idx_q;
    assign zero_en      = (state_q == SCRUB_ZERO);
    assign zero_idx     = idx_q;
    assign scrub_busy_o = (state_q != SCRUB_IDLE);

    // Dirty FIFO: pushed with the old index of every accepted write, popped
    // by the state machine. The pool invariant keeps it from overflowing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumSpare); i++) dirty_mem_q[i] <= '0;
            dirty_head_q <= '0;
            dirty_tail_q <= '0;
            dirty_cnt_q  <= '0;
        end else begin
            if (accept) begin
                dirty_mem_q[dirty_tail_q] <= old_idx;
                dirty_tail_q              <= ptr_inc(dirty_tail_q);
            end
            if (dirty_pop) dirty_head_q <= ptr_inc(dirty_head_q);
            case ({accept, dirty_pop})
                2'b10:   dirty_cnt_q <= dirty_cnt_q + 4'd1;
                2'b01:   dirty_cnt_q <= dirty_cnt_q - 4'd1;
                default: dirty_cnt_q <= dirty_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SCRUB_IDLE;
            idx_q   <= '0;
        end else begin
            case (state_q)
                SCRUB_IDLE: begin
                    if (dirty_pop) begin
                        idx_q   <= dirty_mem_q[dirty_head_q];
                        state_q <= SCRUB_ZERO;
                    end
                end
                SCRUB_ZERO:    state_q <= SCRUB_RELEASE;
                SCRUB_RELEASE: state_q <= SCRUB_IDLE;
                default:       state_q <= SCRUB_IDLE;
            endcase
        end
    end
`else
    // Immediate retirement: the replaced register is cleared and recycled on
    // the same edge that pops its successor, so the pool count never moves.
    assign free_push    = accept;
    assign push_idx     = old_idx;
    assign zero_en      = accept;
    assign zero_idx     = old_idx;
    assign scrub_busy_o = 1'b0;
`endif

    // Free pool.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumSpare); i++) free_mem_q[i] <= idx_t'(NumWords + i);
            free_head_q <= '0;
            free_tail_q <= '0;
            free_cnt_q  <= 4'(NumSpare);
        end else begin
            if (accept) free_head_q <= ptr_inc(free_head_q);
            if (free_push) begin
                free_mem_q[free_tail_q] <= push_idx;
                free_tail_q             <= ptr_inc(free_tail_q);
            end
            case ({free_push, accept})
                2'b10:   free_cnt_q <= free_cnt_q + 4'd1;
                2'b01:   free_cnt_q <= free_cnt_q - 4'd1;
                default: free_cnt_q <= free_cnt_q;
            endcase
        end
    end

    // Physical registers. The zeroed index is never mapped and the written
    // index comes from the free pool, so the two targets never coincide.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 1; p < NumPhys; p++) phys_q[p] <= '0;
        end else begin
            for (int p = 1; p < NumPhys; p++) begin
                if (zero_en && (zero_idx == idx_t'(p))) phys_q[p] <= '0;
                if (accept && (head_idx == idx_t'(p)))  phys_q[p] <= wdata_i;
            end
        end
    end

    // Map table.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int a = 1; a < NumWords; a++) map_q[a] <= idx_t'(a);
        end else begin
            for (int a = 1; a < NumWords; a++) begin
                if (accept && (waddr_i == 5'(a))) map_q[a] <= head_idx;
            end
        end
    end

endmodule
